// File: rtl/case_4_mul_share_arb.sv
// case_4_mul_share_arb: one signed DIN0_W x DIN1_W multiplier shared by
// NUM_REQ requesters. A round-robin arbiter feeds a LATENCY-deep stallable
// pipeline whose last stage drives a single valid/ready response port tagged
// with the owning requester id.
//
// Optional build macro CASE_4_MUL_SHARE_ARB_SAT_EN: when defined, the full
// product saturates to the signed DOUT_W range instead of wrapping. Latency
// is identical in both builds.
module case_4_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 2,
  parameter int DIN0_W  = 9,
  parameter int DIN1_W  = 8,
  parameter int DOUT_W  = 9
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DIN0_W-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_W-1:0] req_din1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DOUT_W-1:0]         rsp_dout,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
);

  localparam int PROD_W = DIN0_W + DIN1_W;

`ifdef CASE_4_MUL_SHARE_ARB_SAT_EN
  // Largest positive DOUT_W value; its complement is the most negative one.
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (DOUT_W - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Round-robin pointer: first requester examined by the next scan.
  logic [ID_W-1:0]          ptr_q, ptr_d;

  // Per-stage valid and owner id; stage LATENCY-1 drives the response port.
  logic [LATENCY-1:0]       vld_q;
  logic [ID_W-1:0]          id_q [LATENCY];

  // Stage-0 operands; the product is formed from these.
  logic signed [DIN0_W-1:0] din0_q, din0_d;
  logic signed [DIN1_W-1:0] din1_q, din1_d;

  logic                     stall;
  logic                     accept;
  logic                     grant_found;
  logic [ID_W-1:0]          grant;
  logic                     hi_found, lo_found;
  logic [ID_W-1:0]          hi_idx, lo_idx;
  logic signed [PROD_W-1:0] prod;
  logic [DOUT_W-1:0]        res_d;

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_id    = id_q[LATENCY-1];
  assign busy      = |vld_q;

  // A presented but unconsumed result freezes the whole pipeline.
  assign stall     = rsp_valid & ~rsp_ready;

  // Round-robin scan: first valid requester at or above ptr, else the first
  // valid one below ptr (the wrapped part of the scan).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
      end
      if (req_valid[i] && !hi_found && (i >= int'(ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = ID_W'(i);
      end
    end
    grant_found = hi_found | lo_found;
    grant       = hi_found ? hi_idx : lo_idx;
  end

  // Grant is offered only when the pipeline can move and reset is released.
  assign accept    = grant_found & ~stall & ~ap_rst;
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;

  // Select the granted requester's operands and the post-accept pointer.
  always_comb begin
    din0_d = '0;
    din1_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(grant) == i) begin
        din0_d = req_din0[i*DIN0_W +: DIN0_W];
        din1_d = req_din1[i*DIN1_W +: DIN1_W];
      end
    end
    ptr_d = ptr_q;
    if (accept) begin
      if (int'(grant) == NUM_REQ - 1) ptr_d = '0;
      else                            ptr_d = grant + ID_W'(1);
    end
  end

  // Full-width signed product of the stage-0 operands, then wrap or saturate.
  always_comb begin
    prod = PROD_W'(din0_q) * PROD_W'(din1_q);
`ifdef CASE_4_MUL_SHARE_ARB_SAT_EN
    if (prod > SAT_MAX)      res_d = DOUT_W'(SAT_MAX);
    else if (prod < SAT_MIN) res_d = DOUT_W'(SAT_MIN);
    else                     res_d = DOUT_W'(prod);
`else
    res_d = DOUT_W'(prod);
`endif
  end

  // Arbiter pointer, stage-0 capture and valid/id shift register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its predecessor's pre-edge value regardless of statement order.
    if (ap_rst) begin
      ptr_q  <= '0;
      vld_q  <= '0;
      din0_q <= '0;
      din1_q <= '0;
      for (int k = 0; k < LATENCY; k++) id_q[k] <= '0;
    end else if (!stall) begin
      ptr_q    <= ptr_d;
      vld_q[0] <= accept;
      if (accept) begin
        id_q[0] <= grant;
        din0_q  <= din0_d;
        din1_q  <= din1_d;
      end
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_lat1
    // Single-stage pipeline: the result is combinational from stage 0.
    assign rsp_dout = res_d;
  end else begin : g_latn
    logic [DOUT_W-1:0] res_q [1:LATENCY-1];

    // Result shift register; stage 1 captures the finished product.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
      // NOTE: the data stages are reset (not just their valids) because the
      // response data must read zero straight out of reset.
      if (ap_rst) begin
        for (int k = 1; k < LATENCY; k++) res_q[k] <= '0;
      end else if (!stall) begin
        res_q[1] <= res_d;
        for (int k = 2; k < LATENCY; k++) res_q[k] <= res_q[k-1];
      end
    end

    assign rsp_dout = res_q[LATENCY-1];
  end

endmodule

// File: tb/tb_case_4_mul_share_arb.sv
// Testbench for case_4_mul_share_arb. Directed steps followed by random
// traffic, all scored against a queue-based reference model of in-flight
// operations. Expected products follow CASE_4_MUL_SHARE_ARB_SAT_EN when the
// macro is defined for the bench as well.
module tb_case_4_mul_share_arb;

  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int LAT = 2;
  localparam int W0  = 9;
  localparam int W1  = 8;
  localparam int WO  = 9;

  logic              ap_clk;
  logic              ap_rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W0-1:0]  req_din0;
  logic [NR*W1-1:0]  req_din1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WO-1:0]     rsp_dout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  case_4_mul_share_arb #(
    .NUM_REQ(NR), .ID_W(IDW), .LATENCY(LAT),
    .DIN0_W(W0), .DIN1_W(W1), .DOUT_W(WO)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dout  (rsp_dout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Reference model: in-flight operations in acceptance order. 'age' counts
  // non-stalled edges since acceptance; an op is presented at age LAT-1.
  typedef struct {
    int          id;
    logic [8:0]  dout;
    int          age;
  } op_t;

  op_t q[$];
  int  ptr_m;
  int  n_cmp;
  int  n_bad;

  function automatic logic [8:0] ref_mul(input logic [8:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
`ifdef CASE_4_MUL_SHARE_ARB_SAT_EN
    if (p > 255)  p = 255;
    if (p < -256) p = -256;
`endif
    return 9'(p);
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr_m + k) % NR;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [8:0] a, input logic [7:0] b);
    req_din0[r*W0 +: W0] = a;
    req_din1[r*W1 +: W1] = b;
  endtask

  // One clock cycle: score outputs at the falling edge, then apply the
  // model's view of the rising edge. Returns at posedge + 1.
  task automatic step();
    logic exp_valid;
    logic stall_m;
    int   g;
    op_t  op;
    @(negedge ap_clk);
    exp_valid = (q.size() != 0) && (q[0].age == LAT - 1);
    check("rsp_valid", rsp_valid, exp_valid);
    check("busy", busy, q.size() != 0);
    stall_m = exp_valid && !rsp_ready;
    g = stall_m ? -1 : model_grant();
    check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (exp_valid) begin
      check("rsp_dout", rsp_dout, q[0].dout);
      check("rsp_id", rsp_id, q[0].id);
    end
    if (!stall_m) begin
      if (exp_valid) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (g >= 0) begin
        op.id   = g;
        op.dout = ref_mul(req_din0[g*W0 +: W0], req_din1[g*W1 +: W1]);
        op.age  = 0;
        q.push_back(op);
        ptr_m = (g + 1) % NR;
      end
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Assert reset between edges, check the immediate effect, release it.
  task automatic do_reset();
    req_valid = '0;
    ap_rst    = 1'b1;
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", req_ready, '0);
    q.delete();
    ptr_m = 0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
  endtask

  logic [3:0] sparse_exp [3];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    ptr_m     = 0;
    ap_rst    = 1'b1;
    req_valid = '1;
    req_din0  = '0;
    req_din1  = '0;
    rsp_ready = 1'b1;

    // Reset state, with all requesters asking (grant must be suppressed).
    #2;
    check("init_req_ready", req_ready, '0);
    check("init_rsp_valid", rsp_valid, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_rsp_dout", rsp_dout, '0);
    check("init_rsp_id", rsp_id, '0);
    req_valid = '0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // Single op: 255 * 2.
    set_op(0, 9'h0FF, 8'h02);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    check("single_early", rsp_valid, 1'b0);
    for (int i = 0; i < LAT - 1; i++) step();
    check("single_valid", rsp_valid, 1'b1);
`ifdef CASE_4_MUL_SHARE_ARB_SAT_EN
    check("single_dout", rsp_dout, 9'h0FF);
`else
    check("single_dout", rsp_dout, 9'h1FE);
`endif
    check("single_id", rsp_id, '0);
    step();

    // Signed operands, including the most negative extremes.
    set_op(0, 9'd3, 8'hFB);
    req_valid = 4'b0001;
    step();
    set_op(0, 9'h100, 8'h80);
    step();
    req_valid = '0;
    check("signed_neg15", rsp_dout, 9'h1F1);
    step();
`ifdef CASE_4_MUL_SHARE_ARB_SAT_EN
    check("signed_extreme", rsp_dout, 9'h0FF);
`else
    check("signed_extreme", rsp_dout, 9'h000);
`endif
    step();

    // Fairness from ptr=0: grants rotate 0,1,2,3,...
    do_reset();
    for (int r = 0; r < NR; r++) set_op(r, 9'($urandom), 8'($urandom));
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fair_grant", req_ready, 32'd1 << (i % NR));
      if (i >= LAT) begin
        check("fair_rsp_valid", rsp_valid, 1'b1);
        check("fair_rsp_id", rsp_id, (i - LAT) % NR);
      end
      step();
    end

    // Backpressure with a full pipeline: everything holds for 3 cycles.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", req_ready, '0);
      check("bp_dout", rsp_dout, q[0].dout);
      check("bp_id", rsp_id, q[0].id);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req_valid = '0;
    for (int i = 0; i < LAT + 1; i++) step();

    // Sparse: move ptr to 2 via requester 1, then 1 and 3 alternate from 3.
    do_reset();
    req_valid = 4'b0010;
    step();
    sparse_exp[0] = 4'b1000;
    sparse_exp[1] = 4'b0010;
    sparse_exp[2] = 4'b1000;
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sparse_grant", req_ready, sparse_exp[i]);
      step();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) step();

    // Reset mid-operation with two ops in flight.
    req_valid = 4'b0100;
    step();
    step();
    #3;
    do_reset();
    req_valid = '1;
    #1;
    check("post_rst_grant", req_ready, 4'b0001);
    step();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = NR'($urandom);
      req_din0  = (NR*W0)'({$urandom, $urandom});
      req_din1  = (NR*W1)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2 * LAT + 2; i++) step();
    check("drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/case_4_mul_share_arb.md
Name: case_4_mul_share_arb

Overview:
- Shares one signed 9s x 8s -> 9-bit multiplier datapath among NUM_REQ requesters.
- Round-robin arbitration, a LATENCY-deep stallable pipeline, and a single valid/ready response port tagged with the requester id.
- Sits between the case_4 compute kernels and the multiplier resource, so the kernels need only one multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- LATENCY, 2, accept-to-response pipeline depth in cycles (1..4).
- DIN0_W, 9, signed operand 0 width.
- DIN1_W, 8, signed operand 1 width.
- DOUT_W, 9, result width.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_din0  in  NUM_REQ*DIN0_W  operand 0; requester i uses slice [i*DIN0_W +: DIN0_W].
- req_din1  in  NUM_REQ*DIN1_W  operand 1; requester i uses slice [i*DIN1_W +: DIN1_W].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_dout  out  DOUT_W  signed result.
- rsp_id  out  ID_W  index of the requester that owns rsp_dout.
- busy  out  1  high while any pipeline stage holds valid data.

Behaviour:
- Reset (async, immediate on ap_rst rise):
  - All stage valid bits clear; rsp_valid=0, rsp_dout=0, rsp_id=0, busy=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while ap_rst is high.
  - In-flight operations are discarded and never replayed.
- Stall: stall = rsp_valid & ~rsp_ready. When stall=1, every stage holds, req_ready=0 and no grant occurs.
- Arbitration (combinational, when stall=0):
  - Scan requesters ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - The first requester with req_valid=1 is granted g; req_ready[g]=1 and all other req_ready bits are 0.
  - No requester valid: req_ready=0 and a bubble enters stage 0.
  - req_ready never depends on the granted requester's own req_valid beyond the scan.
- Accept occurs when req_valid[g] & req_ready[g] at a rising edge:
  - Stage 0 captures din0, din1 and id=g with valid=1.
  - ptr <= (g+1) mod NUM_REQ.
  - ptr is unchanged on cycles with no accept.
- Pipeline:
  - When stall=0, stage k+1 <= stage k every cycle, bubbles included.
  - The product is formed from stage-0 operands: signed DIN0_W x signed DIN1_W = 17-bit full product.
  - The result is carried through the remaining stages.
  - The last stage drives rsp_*.
  - An operation accepted at edge t presents rsp_valid=1 after edge t+LATENCY-1 when no stall occurs.
  - Throughput is one result per cycle.
- Width rule: rsp_dout = low DOUT_W bits of the 17-bit two's-complement product (wrap/truncate).
- Response handshake:
  - rsp_dout and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
  - The result is consumed on the edge where rsp_valid & rsp_ready.
- Simultaneous events:
  - An accept and a response consumption on the same edge are both legal.
  - A requester deasserting valid in the same cycle it would be granted gets no grant; the scan uses current inputs only.
- Ordering: results leave in acceptance order; rsp_id identifies the owner.
- busy = OR of all stage valid bits.

Optional Feature:
- Macro: CASE_4_MUL_SHARE_ARB_SAT_EN.
- Defined: rsp_dout saturates the 17-bit product to the signed DOUT_W range [-256, 255] instead of wrapping. Saturation is applied before the last stage register; latency is unchanged.
- Undefined: plain low-bit truncation as above.

Test Plan:
- Single op, no saturation: requester 0, din0=9'h0FF (255), din1=8'h02, rsp_ready=1 -> rsp_valid after LATENCY-1 edges, rsp_dout=9'h1FE, rsp_id=0. With CASE_4_MUL_SHARE_ARB_SAT_EN defined -> rsp_dout=9'h0FF.
- Signed values: din0=3, din1=-5 -> rsp_dout=9'h1F1 (-15). Then din0=-256, din1=-128 -> 9'h000 with wrap, 9'h0FF with saturation.
- Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 one per cycle; rsp_id follows the same sequence; no cycle without a response after the pipeline fills.
- Backpressure: pipeline full, rsp_ready=0 for 3 cycles -> req_ready=0 throughout; rsp_dout and rsp_id unchanged. After rsp_ready=1, results resume in order with none lost or duplicated.
- Sparse requests: only requesters 1 and 3 valid with ptr=2 -> grant 3, then 1, then 3; bubbles produce no rsp_valid.
- Reset mid-operation: 2 ops in flight, assert ap_rst between edges -> rsp_valid=0 and busy=0 immediately, before the next edge. After release, the first grant goes to requester 0 if it is valid.
